// File: rtl/calc_defs.sv
// -----------------------------------------------------------------------------
// calc_defs
// Shared definitions for the calculator display back end:
//   - state_t     : conversion FSM encoding (IDLE, CONV, SHOW)
//   - SEG_*       : active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK   : all segments off
//   - DIG_*       : scan digit-index values
//   - add3()      : double-dabble nibble correction
// No ports; this is a package.
// -----------------------------------------------------------------------------
package calc_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Number of shift steps needed to convert an 8-bit value.
    localparam int unsigned CONV_STEPS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_UNUSED   = 2'd3;

    // A nibble of 5 or more would exceed 9 after the next doubling,
    // so it is pre-corrected by +3.
    function automatic logic [3:0] add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   digit  in  4  BCD digit 0..9
//   blank  in  1  force all segments off
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-low
// Codes above 9 cannot reach this decoder; they decode as blank.
// -----------------------------------------------------------------------------
module seg7_decode
    import calc_defs::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
// Converts an 8-bit unsigned result to three BCD digits (double dabble, one
// bit per clock) and drives a 4-digit multiplexed active-low seven-segment
// display with leading-zero blanking.
// Ports:
//   clk     in  1  system clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   result  in  8  value to convert, sampled when load is accepted
//   load    in  1  conversion request
//   busy    out 1  conversion in progress
//   done    out 1  one-cycle pulse when new digits are committed
//   an      out 4  digit anodes, active-low (0=ones,1=tens,2=hundreds,3 unused)
//   seg     out 7  segments {g,f,e,d,c,b,a}, active-low
//
// Handshake: a request is taken on any rising edge where load=1 and busy=0.
// busy is high for the 8 conversion clocks that follow; a load seen while
// busy=1 is dropped, not queued. done pulses for the cycle after the final
// step and a new load may be accepted in that same cycle.
// -----------------------------------------------------------------------------
module result_display
    import calc_defs::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg
);

    // ---------------------------------------------------------------------
    // Conversion FSM
    // ---------------------------------------------------------------------
    state_t state;
    state_t state_next;

    logic [2:0]  step;
    logic [7:0]  shift_reg;
    logic [11:0] bcd;
    logic        accept;
    logic        last_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            ST_IDLE, ST_SHOW: begin
                if (load) begin
                    accept     = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                busy = 1'b1;
                if (step == 3'(CONV_STEPS - 1)) begin
                    last_step  = 1'b1;
                    state_next = ST_SHOW;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Double-dabble datapath
    // ---------------------------------------------------------------------
    logic [11:0] bcd_adj;
    logic [19:0] dd_next;

    always_comb begin
        bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        // Shift the whole {bcd, shift} chain; the top bit falls off and is
        // always zero for 8-bit inputs.
        dd_next = {bcd_adj, shift_reg} << 1;
    end

    logic [3:0] dig_hundreds;
    logic [3:0] dig_tens;
    logic [3:0] dig_ones;
    logic       valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            bcd          <= '0;
            step         <= '0;
            dig_hundreds <= '0;
            dig_tens     <= '0;
            dig_ones     <= '0;
            valid        <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= last_step;
            if (accept) begin
                shift_reg <= result;
                bcd       <= '0;
                step      <= '0;
            end else if (busy) begin
                shift_reg <= dd_next[7:0];
                bcd       <= dd_next[19:8];
                step      <= step + 3'd1;
                // Commit the result of this final step directly, so the
                // digits land on the same edge that ends the conversion.
                if (last_step) begin
                    dig_hundreds <= dd_next[19:16];
                    dig_tens     <= dd_next[15:12];
                    dig_ones     <= dd_next[11:8];
                    valid        <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Display scan: free-running, never stalled by conversion
    // ---------------------------------------------------------------------
    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              digit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign digit_idx = cnt[REFRESH_BITS-1:REFRESH_BITS-2];

    logic [3:0] mux_digit;
    logic       mux_blank;
    logic [3:0] an_next;
    logic [6:0] seg_next;

    always_comb begin
        mux_digit = 4'd0;
        mux_blank = 1'b1;
        case (digit_idx)
            DIG_ONES: begin
                mux_digit = dig_ones;
                mux_blank = !valid;
            end
            DIG_TENS: begin
                mux_digit = dig_tens;
                mux_blank = !valid || (dig_hundreds == 4'd0 && dig_tens == 4'd0);
            end
            DIG_HUNDREDS: begin
                mux_digit = dig_hundreds;
                mux_blank = !valid || (dig_hundreds == 4'd0);
            end
            DIG_UNUSED: begin
                mux_digit = 4'd0;
                mux_blank = 1'b1;
            end
            default: begin
                mux_digit = 4'd0;
                mux_blank = 1'b1;
            end
        endcase
        an_next = mux_blank ? 4'b1111 : ~(4'b0001 << digit_idx);
    end

    seg7_decode u_decode (
        .digit (mux_digit),
        .blank (mux_blank),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// -----------------------------------------------------------------------------
// tb_result_display
// Directed, table-driven bench for result_display with REFRESH_BITS=4
// (4 clocks per digit, 16-clock scan). Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_result_display;

    localparam int RB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;

    int checks   = 0;
    int failures = 0;

    result_display #(.REFRESH_BITS(RB)) dut (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .an     (an),
        .seg    (seg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Reference scan counter: counts rising edges since reset.
    logic [3:0] ref_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) ref_cnt <= 4'd0;
        else     ref_cnt <= ref_cnt + 4'd1;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] value;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [2:0] lit;   // which of {hundreds,tens,ones} are lit
    } vec_t;

    vec_t       vecs [8];
    logic [6:0] seg_tab [10];

    localparam int V255 = 0, V0 = 1, V9 = 2, V100 = 3, V45 = 4, V10 = 5, V37 = 6, V128 = 7;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected an/seg for the digits of vector vi (vi<0: nothing valid).
    // Outputs lag the scan counter by one clock.
    task automatic check_disp(input int vi, input string tag);
        logic [3:0] prev;
        logic [1:0] idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        prev    = ref_cnt - 4'd1;
        idx     = prev[3:2];
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
        if (vi >= 0) begin
            case (idx)
                2'd0: if (vecs[vi].lit[0]) begin exp_an = 4'b1110; exp_seg = seg_tab[vecs[vi].o]; end
                2'd1: if (vecs[vi].lit[1]) begin exp_an = 4'b1101; exp_seg = seg_tab[vecs[vi].t]; end
                2'd2: if (vecs[vi].lit[2]) begin exp_an = 4'b1011; exp_seg = seg_tab[vecs[vi].h]; end
                default: ;
            endcase
        end
        check({tag, " an"}, 32'(an), 32'(exp_an));
        check({tag, " seg"}, 32'(seg), 32'(exp_seg));
    endtask

    // Starts at a falling edge, drives a load, checks busy/done/display
    // through the 8 steps, returns at the falling edge where done=1.
    // inject>=0 raises a second load (result=200) after that busy edge.
    task automatic run_conv(input int vi, input int old_vi, input int inject, input string tag);
        result = vecs[vi].value;
        load   = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            load = 1'b0;
            if (k == inject) begin
                result = 8'd200;
                load   = 1'b1;
            end
            check({tag, " busy"}, 32'(busy), 32'(k < 8));
            check({tag, " done"}, 32'(done), 32'(k == 8));
            check_disp(old_vi, {tag, " hold"});
        end
    endtask

    // One clock after done, then a full scan of the new digits.
    task automatic show_window(input int vi, input string tag);
        logic [2:0] low;
        low = 3'b000;
        tick();
        for (int k = 0; k < 16; k++) begin
            check({tag, " done_low"}, 32'(done), 32'd0);
            check({tag, " busy_low"}, 32'(busy), 32'd0);
            check_disp(vi, {tag, " scan"});
            low = low | ~an[2:0];
            tick();
        end
        check({tag, " lit_mask"}, 32'(low), 32'(vecs[vi].lit));
    endtask

    // ---------------- test ----------------
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        vecs[V255] = '{8'd255, 4'd2, 4'd5, 4'd5, 3'b111};
        vecs[V0]   = '{8'd0,   4'd0, 4'd0, 4'd0, 3'b001};
        vecs[V9]   = '{8'd9,   4'd0, 4'd0, 4'd9, 3'b001};
        vecs[V100] = '{8'd100, 4'd1, 4'd0, 4'd0, 3'b111};
        vecs[V45]  = '{8'd45,  4'd0, 4'd4, 4'd5, 3'b011};
        vecs[V10]  = '{8'd10,  4'd0, 4'd1, 4'd0, 3'b011};
        vecs[V37]  = '{8'd37,  4'd0, 4'd3, 4'd7, 3'b011};
        vecs[V128] = '{8'd128, 4'd1, 4'd2, 4'd8, 3'b111};

        rst    = 1'b1;
        load   = 1'b0;
        result = 8'd0;
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset an", 32'(an), 32'hf);
        check("reset seg", 32'(seg), 32'h7f);
        rst = 1'b0;

        // Idle: display blank, no activity.
        for (int k = 0; k < 40; k++) begin
            tick();
            check("idle busy", 32'(busy), 32'd0);
            check("idle done", 32'(done), 32'd0);
            check_disp(-1, "idle");
        end

        run_conv(V255, -1, -1, "c255");
        show_window(V255, "s255");
        run_conv(V0, V255, -1, "c0");
        show_window(V0, "s0");
        run_conv(V9, V0, -1, "c9");
        show_window(V9, "s9");
        run_conv(V100, V9, -1, "c100");
        show_window(V100, "s100");

        // Back-to-back: the second load is driven in the done cycle.
        run_conv(V45, V100, -1, "c45");
        run_conv(V10, V45, -1, "c10");
        show_window(V10, "s10");

        // Load during busy is dropped; one done pulse only.
        run_conv(V37, V10, 2, "c37");
        show_window(V37, "s37");

        // Reset in the middle of a conversion.
        result = 8'd128;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("abort an", 32'(an), 32'hf);
        check("abort seg", 32'(seg), 32'h7f);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("post_abort done", 32'(done), 32'd0);
            check("post_abort busy", 32'(busy), 32'd0);
            check_disp(-1, "post_abort");
        end
        run_conv(V128, -1, -1, "c128");
        show_window(V128, "s128");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
